// File: rtl/heap_mem_pkg.sv
// heap_mem_pkg: shared constants, slot layout and FSM encoding for the heap
// memory sequencer.
//
// Slot layouts, MSB first:
//   read slot  : {tag[1:0], addr[ADDR_W-1:0], pad[VAL_W-ADDR_W-1:0]}
//   write slot : {tag[1:0], addr[ADDR_W-1:0], data[VAL_W-1:0]}
// A slot is present whenever its tag is not TAG_NONE.
package heap_mem_pkg;

    localparam int ADDR_W = 30;
    localparam int VAL_W  = 63;
    localparam int TAG_W  = 2;

    localparam logic [TAG_W-1:0] TAG_NONE = 2'b00;
    localparam logic [TAG_W-1:0] TAG_SOME = 2'b01;

    localparam int RD_SLOT_W = TAG_W + VAL_W;
    localparam int WR_SLOT_W = TAG_W + ADDR_W + VAL_W;

    // Field offsets inside a slot (tag on top, address directly below it).
    localparam int TAG_LSB_RD  = VAL_W;
    localparam int TAG_LSB_WR  = ADDR_W + VAL_W;
    localparam int ADDR_LSB_RD = VAL_W - ADDR_W;
    localparam int ADDR_LSB_WR = VAL_W;

    // Bit positions in the 4-bit presence vector; also the issue order.
    localparam int SLOT_WR_A = 0;
    localparam int SLOT_WR_B = 1;
    localparam int SLOT_RD_A = 2;
    localparam int SLOT_RD_B = 3;

    // Op states are encoded as presence-vector index + 1.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_A    = 3'd1,
        ST_WR_B    = 3'd2,
        ST_RD_A    = 3'd3,
        ST_RD_B    = 3'd4,
        ST_RD_WAIT = 3'd5,
        ST_RSP     = 3'd6
    } heap_state_t;

    // First present op at or after index 'start'; once none remain, wait a
    // cycle for read data if any read is part of the bundle.
    function automatic heap_state_t next_op_state(input logic [3:0] pres,
                                                  input int start);
        heap_state_t nxt;
        nxt = (pres[SLOT_RD_A] | pres[SLOT_RD_B]) ? ST_RD_WAIT : ST_RSP;
        for (int i = 3; i >= 0; i--) begin
            if (i >= start && pres[i]) nxt = heap_state_t'(3'(i + 1));
        end
        return nxt;
    endfunction

endpackage

// File: rtl/heap_slot_unpack.sv
// heap_slot_unpack: combinational split of one request slot.
//
// Ports:
//   slot    in  SLOT_W   packed slot {tag, addr, field}
//   present out 1        tag != TAG_NONE
//   addr    out ADDR_W   heap address
//   field   out FIELD_W  write data (write slot) or pad (read slot)
module heap_slot_unpack #(
    parameter int ADDR_W  = heap_mem_pkg::ADDR_W,
    parameter int SLOT_W  = heap_mem_pkg::WR_SLOT_W,
    parameter int FIELD_W = SLOT_W - heap_mem_pkg::TAG_W - ADDR_W
) (
    input  logic [SLOT_W-1:0]  slot,
    output logic               present,
    output logic [ADDR_W-1:0]  addr,
    output logic [FIELD_W-1:0] field
);
    import heap_mem_pkg::*;

    assign present = (slot[SLOT_W-1 -: TAG_W] != TAG_NONE);
    assign addr    = slot[SLOT_W-TAG_W-1 -: ADDR_W];
    assign field   = slot[FIELD_W-1:0];

endmodule

// File: rtl/heap_mem_sequencer.sv
// heap_mem_sequencer: serialises one bundle of up to two writes and two reads
// onto a single-port synchronous heap SRAM (writes first, then reads) and
// returns one completion carrying the read data.
//
// Ports:
//   system1000        in   clock
//   system1000_rstn   in   asynchronous active-low reset
//   req_valid/ready   in/out  bundle handshake
//   req_rd_a/b        in   read slots  {tag, addr, pad}
//   req_wr_a/b        in   write slots {tag, addr, data}
//   mem_en/we/addr/wdata  out  SRAM strobe, write flag, address, write data
//   mem_rdata         in   SRAM read data, valid the cycle after a read strobe
//   rsp_valid/ready   out/in  completion handshake
//   rsp_rd_a/b        out  read data (0 for absent slots)
//   stat_ops          out  saturating count of mem_en cycles
//                          (only when HEAP_SEQ_STATS_EN is defined)
module heap_mem_sequencer #(
    parameter int ADDR_W = heap_mem_pkg::ADDR_W,
    parameter int VAL_W  = heap_mem_pkg::VAL_W
) (
    input  logic                      system1000,
    input  logic                      system1000_rstn,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [VAL_W+1:0]          req_rd_a,
    input  logic [VAL_W+1:0]          req_rd_b,
    input  logic [ADDR_W+VAL_W+1:0]   req_wr_a,
    input  logic [ADDR_W+VAL_W+1:0]   req_wr_b,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [VAL_W-1:0]          mem_wdata,
    input  logic [VAL_W-1:0]          mem_rdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [VAL_W-1:0]          rsp_rd_a,
    output logic [VAL_W-1:0]          rsp_rd_b
`ifdef HEAP_SEQ_STATS_EN
    ,
    output logic [31:0]               stat_ops
`endif
);
    import heap_mem_pkg::*;

    localparam int RD_W  = VAL_W + TAG_W;
    localparam int WR_W  = ADDR_W + VAL_W + TAG_W;
    localparam int PAD_W = VAL_W - ADDR_W;

    heap_state_t state, state_nxt;

    logic [3:0]        pres_in;
    logic [ADDR_W-1:0] wr_a_addr_in, wr_b_addr_in, rd_a_addr_in, rd_b_addr_in;
    logic [VAL_W-1:0]  wr_a_data_in, wr_b_data_in;
    logic [PAD_W-1:0]  rd_a_pad_unused, rd_b_pad_unused;

    logic [3:0]        pres_q;
    logic [ADDR_W-1:0] wr_a_addr_q, wr_b_addr_q, rd_a_addr_q, rd_b_addr_q;
    logic [VAL_W-1:0]  wr_a_data_q, wr_b_data_q;

    logic              cap_a_p1, cap_b_p1;
    logic [VAL_W-1:0]  rd_a_q, rd_b_q;
    logic              accept;

    heap_slot_unpack #(.ADDR_W(ADDR_W), .SLOT_W(WR_W)) u_wr_a (
        .slot(req_wr_a), .present(pres_in[SLOT_WR_A]),
        .addr(wr_a_addr_in), .field(wr_a_data_in)
    );
    heap_slot_unpack #(.ADDR_W(ADDR_W), .SLOT_W(WR_W)) u_wr_b (
        .slot(req_wr_b), .present(pres_in[SLOT_WR_B]),
        .addr(wr_b_addr_in), .field(wr_b_data_in)
    );
    heap_slot_unpack #(.ADDR_W(ADDR_W), .SLOT_W(RD_W)) u_rd_a (
        .slot(req_rd_a), .present(pres_in[SLOT_RD_A]),
        .addr(rd_a_addr_in), .field(rd_a_pad_unused)
    );
    heap_slot_unpack #(.ADDR_W(ADDR_W), .SLOT_W(RD_W)) u_rd_b (
        .slot(req_rd_b), .present(pres_in[SLOT_RD_B]),
        .addr(rd_b_addr_in), .field(rd_b_pad_unused)
    );

    // req_ready is gated by reset so nothing is accepted while it is held.
    assign req_ready = (state == ST_IDLE) && system1000_rstn;
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state == ST_RSP);

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) state <= ST_IDLE;
        else                  state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:    if (accept) state_nxt = next_op_state(pres_in, SLOT_WR_A);
            ST_WR_A:    state_nxt = next_op_state(pres_q, SLOT_WR_B);
            ST_WR_B:    state_nxt = next_op_state(pres_q, SLOT_RD_A);
            ST_RD_A:    state_nxt = next_op_state(pres_q, SLOT_RD_B);
            ST_RD_B:    state_nxt = next_op_state(pres_q, SLOT_RD_B + 1);
            ST_RD_WAIT: state_nxt = ST_RSP;
            ST_RSP:     if (rsp_ready) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (state)
            ST_WR_A: begin
                mem_en = 1'b1; mem_we = 1'b1;
                mem_addr = wr_a_addr_q; mem_wdata = wr_a_data_q;
            end
            ST_WR_B: begin
                mem_en = 1'b1; mem_we = 1'b1;
                mem_addr = wr_b_addr_q; mem_wdata = wr_b_data_q;
            end
            ST_RD_A: begin
                mem_en = 1'b1; mem_addr = rd_a_addr_q;
            end
            ST_RD_B: begin
                mem_en = 1'b1; mem_addr = rd_b_addr_q;
            end
            default: ;
        endcase
    end

    // Bundle latch: addresses and data need no reset, they are only used
    // in op states reached through an accept.
    always_ff @(posedge system1000) begin
        if (accept) begin
            pres_q      <= pres_in;
            wr_a_addr_q <= wr_a_addr_in;
            wr_b_addr_q <= wr_b_addr_in;
            rd_a_addr_q <= rd_a_addr_in;
            rd_b_addr_q <= rd_b_addr_in;
            wr_a_data_q <= wr_a_data_in;
            wr_b_data_q <= wr_b_data_in;
        end
    end

    // Read-data stage: _p1 flags mark the cycle after a read strobe.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            cap_a_p1 <= 1'b0;
            cap_b_p1 <= 1'b0;
            rd_a_q   <= '0;
            rd_b_q   <= '0;
        end else begin
            cap_a_p1 <= (state == ST_RD_A);
            cap_b_p1 <= (state == ST_RD_B);
            if (accept) begin
                rd_a_q <= '0;
                rd_b_q <= '0;
            end
            if (cap_a_p1) rd_a_q <= mem_rdata;
            if (cap_b_p1) rd_b_q <= mem_rdata;
        end
    end

    assign rsp_rd_a = rd_a_q;
    assign rsp_rd_b = rd_b_q;

`ifdef HEAP_SEQ_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [31:0] stat_q;

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) stat_q <= '0;
        else if (mem_en)      stat_q <= sat_inc(stat_q);
    end

    assign stat_ops = stat_q;
`endif

endmodule

// File: tb/tb_heap_mem_sequencer.sv
module tb_heap_mem_sequencer;
    import heap_mem_pkg::*;

    logic                  system1000;
    logic                  system1000_rstn;
    logic                  req_valid;
    logic                  req_ready;
    logic [VAL_W+1:0]      req_rd_a, req_rd_b;
    logic [WR_SLOT_W-1:0]  req_wr_a, req_wr_b;
    logic                  mem_en, mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [VAL_W-1:0]      mem_wdata;
    logic [VAL_W-1:0]      mem_rdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [VAL_W-1:0]      rsp_rd_a, rsp_rd_b;
`ifdef HEAP_SEQ_STATS_EN
    logic [31:0]           stat_ops;
`endif

    int checks   = 0;
    int failures = 0;

    heap_mem_sequencer dut (
        .system1000      (system1000),
        .system1000_rstn (system1000_rstn),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_rd_a        (req_rd_a),
        .req_rd_b        (req_rd_b),
        .req_wr_a        (req_wr_a),
        .req_wr_b        (req_wr_b),
        .mem_en          (mem_en),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_rd_a        (rsp_rd_a),
        .rsp_rd_b        (rsp_rd_b)
`ifdef HEAP_SEQ_STATS_EN
        ,
        .stat_ops        (stat_ops)
`endif
    );

    initial system1000 = 1'b0;
    always #5 system1000 = ~system1000;

    // Synchronous SRAM model with a preload port and a strobe log
    // entry = {we, addr[7:0], wdata[7:0]}.
    logic [VAL_W-1:0] mem [16];
    logic             pl_en;
    logic [3:0]       pl_addr;
    logic [VAL_W-1:0] pl_data;
    logic [16:0]      log_q [$];

    always @(posedge system1000) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        if (mem_en) begin
            log_q.push_back({mem_we, mem_addr[7:0], mem_wdata[7:0]});
            if (mem_we) mem[mem_addr[3:0]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[3:0]];
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [VAL_W+1:0] mk_rd(input logic [1:0] tag, input logic [ADDR_W-1:0] a);
        return {tag, a, {(VAL_W-ADDR_W){1'b1}}};
    endfunction

    function automatic logic [WR_SLOT_W-1:0] mk_wr(input logic [1:0] tag, input logic [ADDR_W-1:0] a,
                                                   input logic [VAL_W-1:0] d);
        return {tag, a, d};
    endfunction

    task automatic preload(input logic [3:0] a, input logic [VAL_W-1:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge system1000); #1;
        pl_en = 1'b0;
    endtask

    // Called at posedge+1 with the DUT idle. Sends one bundle, scrambles the
    // inputs after acceptance, measures latency, checks data, optionally
    // holds rsp_ready low for 'hold' cycles, then completes the handshake.
    task automatic txn(input string nm,
                       input logic [WR_SLOT_W-1:0] wa, input logic [WR_SLOT_W-1:0] wb,
                       input logic [VAL_W+1:0] ra, input logic [VAL_W+1:0] rb,
                       input int exp_lat, input logic [VAL_W-1:0] ea,
                       input logic [VAL_W-1:0] eb, input int hold);
        int lat;
        chk({nm, "_req_ready"}, 64'(req_ready), 64'd1);
        req_wr_a = wa; req_wr_b = wb; req_rd_a = ra; req_rd_b = rb;
        req_valid = 1'b1;
        rsp_ready = 1'b0;
        @(posedge system1000); #1;
        req_valid = 1'b0;
        req_wr_a = '1; req_wr_b = '1; req_rd_a = '1; req_rd_b = '1;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            @(posedge system1000); #1;
            lat++;
        end
        chk({nm, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({nm, "_rd_a"}, 64'(rsp_rd_a), 64'(ea));
        chk({nm, "_rd_b"}, 64'(rsp_rd_b), 64'(eb));
        for (int i = 0; i < hold; i++) begin
            @(posedge system1000); #1;
            chk({nm, "_hold_state"}, {61'd0, rsp_valid, req_ready, mem_en}, 64'b100);
            chk({nm, "_hold_rd_a"}, 64'(rsp_rd_a), 64'(ea));
            chk({nm, "_hold_rd_b"}, 64'(rsp_rd_b), 64'(eb));
        end
        rsp_ready = 1'b1;
        @(posedge system1000); #1;
        rsp_ready = 1'b0;
        chk({nm, "_after_rsp"}, {62'd0, rsp_valid, req_ready}, 64'b01);
    endtask

    initial begin
        int base;
        system1000_rstn = 1'b0;
        req_valid = 1'b0; rsp_ready = 1'b0;
        req_rd_a = '0; req_rd_b = '0; req_wr_a = '0; req_wr_b = '0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;

        // Reset state and SRAM preload.
        preload(4'd7, 63'h33);
        preload(4'd9, 63'h7);
        preload(4'd13, 63'h5A);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_mem", {62'd0, mem_en, mem_we}, 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_rd_a", 64'(rsp_rd_a), 64'd0);
        chk("rst_rsp_rd_b", 64'(rsp_rd_b), 64'd0);
        @(posedge system1000); #1;
        system1000_rstn = 1'b1;
        #1;
        chk("rel_req_ready", 64'(req_ready), 64'd1);
`ifdef HEAP_SEQ_STATS_EN
        chk("rst_stat_ops", 64'(stat_ops), 64'd0);
`endif
        @(posedge system1000); #1;

        // All four slots present.
        base = log_q.size();
        txn("all", mk_wr(TAG_SOME, 30'd5, 63'h11), mk_wr(TAG_SOME, 30'd6, 63'h22),
            mk_rd(TAG_SOME, 30'd6), mk_rd(TAG_SOME, 30'd7), 6, 63'h22, 63'h33, 0);
        chk("all_nstrobe", 64'(log_q.size() - base), 64'd4);
        chk("all_s0", 64'(log_q[base]),   64'h1_05_11);
        chk("all_s1", 64'(log_q[base+1]), 64'h1_06_22);
        chk("all_s2", 64'(log_q[base+2]), 64'h0_06_00);
        chk("all_s3", 64'(log_q[base+3]), 64'h0_07_00);

        // No slots present.
        base = log_q.size();
        txn("none", mk_wr(TAG_NONE, 30'd1, 63'h5), mk_wr(TAG_NONE, 30'd2, 63'h6),
            mk_rd(TAG_NONE, 30'd3), mk_rd(TAG_NONE, 30'd4), 1, 63'h0, 63'h0, 0);
        chk("none_nstrobe", 64'(log_q.size() - base), 64'd0);

        // Only rd_b, tag 11 counts as present.
        base = log_q.size();
        txn("rdb", mk_wr(TAG_NONE, 30'd1, 63'h5), mk_wr(TAG_NONE, 30'd2, 63'h6),
            mk_rd(TAG_NONE, 30'd3), mk_rd(2'b11, 30'd9), 3, 63'h0, 63'h7, 0);
        chk("rdb_nstrobe", 64'(log_q.size() - base), 64'd1);
        chk("rdb_s0", 64'(log_q[base]), 64'h0_09_00);

        // Both writes to addr 4, wr_b wins; rd_a with tag 10.
        base = log_q.size();
        txn("waw", mk_wr(TAG_SOME, 30'd4, 63'hA), mk_wr(TAG_SOME, 30'd4, 63'hB),
            mk_rd(2'b10, 30'd4), mk_rd(TAG_NONE, 30'd0), 5, 63'hB, 63'h0, 0);
        chk("waw_nstrobe", 64'(log_q.size() - base), 64'd3);
        chk("waw_s2", 64'(log_q[base+2]), 64'h0_04_00);

        // Writes only.
        txn("wronly", mk_wr(TAG_SOME, 30'd10, 63'h66), mk_wr(TAG_SOME, 30'd11, 63'h77),
            mk_rd(TAG_NONE, 30'd0), mk_rd(TAG_NONE, 30'd0), 3, 63'h0, 63'h0, 0);

        // Reads with rsp_ready held low for 5 cycles.
        txn("bp", mk_wr(TAG_NONE, 30'd0, 63'h0), mk_wr(TAG_NONE, 30'd0, 63'h0),
            mk_rd(TAG_SOME, 30'd10), mk_rd(TAG_SOME, 30'd11), 4, 63'h66, 63'h77, 5);
`ifdef HEAP_SEQ_STATS_EN
        chk("stat_ops_12", 64'(stat_ops), 64'd12);
`endif

        // Reset asserted during WR_B.
        req_wr_a = mk_wr(TAG_SOME, 30'd12, 63'h1);
        req_wr_b = mk_wr(TAG_SOME, 30'd13, 63'h2);
        req_rd_a = mk_rd(TAG_SOME, 30'd12);
        req_rd_b = mk_rd(TAG_SOME, 30'd13);
        req_valid = 1'b1;
        @(posedge system1000); #1;
        req_valid = 1'b0;
        chk("mid_wr_a_addr", 64'(mem_addr), 64'd12);
        @(posedge system1000); #1;
        chk("mid_wr_b", {61'd0, mem_en, mem_we, mem_addr == 30'd13}, 64'b111);
        system1000_rstn = 1'b0;
        #1;
        chk("mid_rst_mem_en", 64'(mem_en), 64'd0);
        chk("mid_rst_req_ready", 64'(req_ready), 64'd0);
        @(posedge system1000); #1;
        @(posedge system1000); #1;
        system1000_rstn = 1'b1;
        #1;
        chk("mid_rel_req_ready", 64'(req_ready), 64'd1);
`ifdef HEAP_SEQ_STATS_EN
        chk("mid_stat_ops", 64'(stat_ops), 64'd0);
`endif
        for (int i = 0; i < 3; i++) begin
            @(posedge system1000); #1;
            chk("mid_quiet", {62'd0, rsp_valid, mem_en}, 64'd0);
        end
        txn("post_rst", mk_wr(TAG_NONE, 30'd0, 63'h0), mk_wr(TAG_NONE, 30'd0, 63'h0),
            mk_rd(TAG_SOME, 30'd12), mk_rd(TAG_SOME, 30'd13), 4, 63'h1, 63'h5A, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
